// File: rtl/parallel_data_pack_if.sv
// -----------------------------------------------------------------------------
// parallel_data_pack_if
// Bundles both streaming sides of parallel_data_pack.
//   Input side : s_data, s_valid, s_ready, flush
//   Output side: m_data, m_valid, m_ready, m_partial
// Modports:
//   slave  - the packer itself (consumes samples, produces words)
//   master - the environment around it (produces samples, consumes words)
// -----------------------------------------------------------------------------
interface parallel_data_pack_if #(
   parameter int LANE_WIDTH = 16,
   parameter int LANES      = 8
);
   logic [LANE_WIDTH-1:0]       s_data;
   logic                        s_valid;
   logic                        s_ready;
   logic                        flush;
   logic [LANES*LANE_WIDTH-1:0] m_data;
   logic                        m_valid;
   logic                        m_ready;
   logic                        m_partial;

   modport slave (
      input  s_data, s_valid, flush, m_ready,
      output s_ready, m_data, m_valid, m_partial
   );

   modport master (
      output s_data, s_valid, flush, m_ready,
      input  s_ready, m_data, m_valid, m_partial
   );
endinterface

// File: rtl/parallel_data_pack.sv
// -----------------------------------------------------------------------------
// parallel_data_pack
// Gathers LANE_WIDTH-bit samples into one LANES*LANE_WIDTH-bit word. Lane 0
// (lowest bits) holds the first sample of a word. An accumulator collects lanes
// while a single output register holds the previous finished word, so input
// keeps flowing while a word waits for m_ready.
// Ports:
//   clock         single clock
//   reset         synchronous, active-high
//   bus (slave)   s_data/s_valid/s_ready   sample input handshake
//                 flush                    pulse to close a partial word
//                 m_data/m_valid/m_ready   packed word output handshake
//                 m_partial                word was closed by flush
// Build option:
//   PACK_FLUSH_EN  when defined, flush closes a partial word (upper lanes zero,
//                  m_partial=1); otherwise flush is ignored and m_partial is 0.
// -----------------------------------------------------------------------------
module parallel_data_pack #(
   parameter int LANE_WIDTH = 16,
   parameter int LANES      = 8,
   parameter int CNT_W      = $clog2(LANES)
) (
   input  logic                  clock,
   input  logic                  reset,
   parallel_data_pack_if.slave   bus
);
   localparam int              WORD_W = LANES * LANE_WIDTH;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(LANES - 1);

   logic [CNT_W-1:0]  r_cnt;
   logic [WORD_W-1:0] r_acc;
   logic [WORD_W-1:0] r_m_data;
   logic              r_m_valid;

   logic              w_out_free;
   logic              w_last;
   logic              w_s_ready;
   logic              w_accept;
   logic              w_full_close;
   logic              w_part_close;
   logic [CNT_W:0]    w_fill;
   logic [WORD_W-1:0] w_acc_next;

   // Keeps lanes 0..n-1 of a word and zeroes the rest.
   function automatic logic [WORD_W-1:0] keep_lanes(input logic [WORD_W-1:0] word,
                                                    input logic [CNT_W:0]    n);
      logic [WORD_W-1:0] res;
      res = '0;
      for (int k = 0; k < LANES; k++) begin
         if (k < int'(n)) res[k*LANE_WIDTH +: LANE_WIDTH] = word[k*LANE_WIDTH +: LANE_WIDTH];
      end
      return res;
   endfunction

   // The output register can take a new word if it is empty or draining now.
   assign w_out_free   = !r_m_valid || bus.m_ready;
   assign w_last       = (r_cnt == LAST);
   assign w_accept     = bus.s_valid && w_s_ready;
   assign w_full_close = w_accept && w_last;
   // Lanes occupied once this cycle's sample (if any) is written.
   assign w_fill       = {1'b0, r_cnt} + (CNT_W+1)'(w_accept);

   always_comb begin
      w_acc_next = r_acc;
      if (w_accept) w_acc_next[r_cnt*LANE_WIDTH +: LANE_WIDTH] = bus.s_data;
   end

`ifdef PACK_FLUSH_EN
   logic r_flush_pend;
   logic r_m_partial;
   logic w_flush_req;
   logic w_flush_open;

   // A flush that lands on the completing sample is just a normal full word.
   assign w_flush_req  = bus.flush || r_flush_pend;
   assign w_flush_open = w_flush_req && !w_full_close && (w_fill != '0);
   assign w_part_close = w_flush_open && w_out_free;
   // While a flush waits for the output register, no more samples may enter.
   assign w_s_ready    = !r_flush_pend && (!w_last || w_out_free);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_flush_pend <= 1'b0;
         r_m_partial  <= 1'b0;
      end else begin
         if (w_part_close)      r_flush_pend <= 1'b0;
         else if (w_flush_open) r_flush_pend <= 1'b1;
         if (w_full_close)      r_m_partial  <= 1'b0;
         else if (w_part_close) r_m_partial  <= 1'b1;
      end
   end

   assign bus.m_partial = r_m_partial;
`else
   logic w_unused_flush;

   assign w_unused_flush = bus.flush;
   assign w_part_close   = 1'b0;
   assign w_s_ready      = !w_last || w_out_free;
   assign bus.m_partial  = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
      end else begin
         // The accumulator is never cleared on close; later samples overwrite it.
         if (w_accept) r_acc <= w_acc_next;

         if (w_full_close || w_part_close) r_cnt <= '0;
         else if (w_accept)                r_cnt <= r_cnt + CNT_W'(1);

         // Loading a new word wins over clearing on a same-cycle handshake.
         if (w_full_close) begin
            r_m_data  <= w_acc_next;
            r_m_valid <= 1'b1;
         end else if (w_part_close) begin
            r_m_data  <= keep_lanes(w_acc_next, w_fill);
            r_m_valid <= 1'b1;
         end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign bus.s_ready = w_s_ready;
   assign bus.m_data  = r_m_data;
   assign bus.m_valid = r_m_valid;
endmodule

// File: tb/tb_parallel_data_pack.sv
`timescale 1ns/1ps
module tb_parallel_data_pack;
   localparam int LW = 16;
   localparam int LN = 8;
   localparam int WW = LW * LN;

   typedef struct packed {
      logic [WW-1:0] d;
      logic          p;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   exp_t          exp_q[$];
   exp_t          exp_e;
   logic [WW-1:0] mdl_acc = '0;
   int            mdl_n = 0;

   always #5 clock = ~clock;

   parallel_data_pack_if #(.LANE_WIDTH(LW), .LANES(LN)) bus ();

   parallel_data_pack #(.LANE_WIDTH(LW), .LANES(LN), .CNT_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Scoreboard: handshakes are decided at the falling edge, inputs being stable
   // since just after the previous rising edge.
   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_word: got %h partial=%b, expected no word", bus.m_data, bus.m_partial);
            end else begin
               exp_e = exp_q.pop_front();
               if (bus.m_data !== exp_e.d || bus.m_partial !== exp_e.p) begin
                  errors++;
                  $display("FAIL sb_word: got %h partial=%b, want %h partial=%b",
                           bus.m_data, bus.m_partial, exp_e.d, exp_e.p);
               end
            end
         end
         if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) begin
            mdl_acc[mdl_n*LW +: LW] = bus.s_data;
            mdl_n++;
            if (mdl_n == LN) begin
               exp_q.push_back('{d: mdl_acc, p: 1'b0});
               mdl_acc = '0;
               mdl_n   = 0;
            end
         end
`ifdef PACK_FLUSH_EN
         if (bus.flush === 1'b1 && mdl_n > 0) begin
            exp_q.push_back('{d: mdl_acc, p: 1'b1});
            mdl_acc = '0;
            mdl_n   = 0;
         end
`endif
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      bus.s_valid = 1'b0;
      bus.flush   = 1'b0;
      tick();
      tick();
      exp_q.delete();
      mdl_acc = '0;
      mdl_n   = 0;
      reset   = 1'b0;
   endtask

   task automatic test_reset();
      bus.m_ready = 1'b1;
      do_reset();
      @(negedge clock);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
      checks++; if (bus.m_partial !== 1'b0) begin errors++; $display("FAIL reset_m_partial: got %b want 0", bus.m_partial); end
      checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
      tick();
   endtask

   task automatic test_stream();
      logic exp_mv;
      bus.m_ready = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         bus.s_valid = (c <= 16);
         bus.s_data  = 16'(c);
         @(negedge clock);
         exp_mv = (c == 9 || c == 17);
         if (c <= 16) begin
            checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL stream_s_ready c=%0d: got %b want 1", c, bus.s_ready); end
         end
         checks++; if (bus.m_valid !== exp_mv) begin errors++; $display("FAIL stream_m_valid c=%0d: got %b want %b", c, bus.m_valid, exp_mv); end
         if (c == 9) begin
            checks++; if (bus.m_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin errors++; $display("FAIL stream_word1: got %h", bus.m_data); end
         end
         if (c == 17) begin
            checks++; if (bus.m_data !== 128'h0010_000F_000E_000D_000C_000B_000A_0009) begin errors++; $display("FAIL stream_word2: got %h", bus.m_data); end
         end
         tick();
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      bus.m_ready = 1'b0;
      for (int j = 1; j <= 15; j++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(32 + j);
         @(negedge clock);
         checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_s_ready j=%0d: got %b want 1", j, bus.s_ready); end
         tick();
      end
      bus.s_data = 16'h0030;
      for (int s = 0; s < 3; s++) begin
         @(negedge clock);
         checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_s_ready: got %b want 0", bus.s_ready); end
         checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_m_valid: got %b want 1", bus.m_valid); end
         checks++; if (bus.m_data !== 128'h0028_0027_0026_0025_0024_0023_0022_0021) begin errors++; $display("FAIL bp_hold_m_data: got %h", bus.m_data); end
         tick();
      end
      bus.m_ready = 1'b1;
      @(negedge clock);
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_s_ready: got %b want 1", bus.s_ready); end
      tick();
      bus.s_valid = 1'b0;
      @(negedge clock);
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_word2_m_valid: got %b want 1", bus.m_valid); end
      checks++; if (bus.m_data !== 128'h0030_002F_002E_002D_002C_002B_002A_0029) begin errors++; $display("FAIL bp_word2_m_data: got %h", bus.m_data); end
      tick();
      @(negedge clock);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL bp_after_m_valid: got %b want 0", bus.m_valid); end
      tick();
   endtask

   task automatic test_random();
      int            sent = 0;
      int            cyc  = 0;
      logic          held = 1'b0;
      logic [WW-1:0] held_data = '0;
      while (sent < 10000 && cyc < 60000) begin
         bus.s_valid = 1'($urandom_range(0, 1));
         bus.s_data  = 16'($urandom);
         bus.m_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         if (held) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== held_data) begin
               errors++;
               $display("FAIL rand_hold_stable: got valid=%b data=%h want valid=1 data=%h", bus.m_valid, bus.m_data, held_data);
            end
         end
         held      = (bus.m_valid === 1'b1 && bus.m_ready === 1'b0);
         held_data = bus.m_data;
         if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) sent++;
         tick();
         cyc++;
      end
      bus.s_valid = 1'b0;
      checks++; if (sent < 10000) begin errors++; $display("FAIL rand_budget: got %0d samples accepted want 10000", sent); end
   endtask

   task automatic test_drain();
      bus.s_valid = 1'b0;
      bus.flush   = 1'b0;
      bus.m_ready = 1'b1;
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
      tick();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_pending: got %0d words outstanding want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      bus.m_ready = 1'b0;
      for (int j = 1; j <= 13; j++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(64 + j);
         tick();
      end
      bus.s_valid = 1'b0;
      @(negedge clock);
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_m_valid: got %b want 1", bus.m_valid); end
      tick();
      reset = 1'b1;
      tick();
      exp_q.delete();
      mdl_acc = '0;
      mdl_n   = 0;
      reset   = 1'b0;
      @(negedge clock);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rmid_m_valid: got %b want 0", bus.m_valid); end
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rmid_s_ready: got %b want 1", bus.s_ready); end
      tick();
      bus.m_ready = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(80 + j);
         tick();
      end
      bus.s_valid = 1'b0;
      @(negedge clock);
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL rmid_word_valid: got %b want 1", bus.m_valid); end
      checks++; if (bus.m_data !== 128'h0058_0057_0056_0055_0054_0053_0052_0051) begin errors++; $display("FAIL rmid_word_data: got %h", bus.m_data); end
      tick();
   endtask

`ifdef PACK_FLUSH_EN
   task automatic test_flush();
      bus.m_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(10 + j);
         tick();
      end
      bus.s_valid = 1'b0;
      bus.flush   = 1'b1;
      tick();
      bus.flush = 1'b0;
      @(negedge clock);
      checks++; if (bus.m_valid !== 1'b1 || bus.m_partial !== 1'b1) begin errors++; $display("FAIL flush_partial: got valid=%b partial=%b want 1/1", bus.m_valid, bus.m_partial); end
      checks++; if (bus.m_data !== 128'h000C_000B_000A) begin errors++; $display("FAIL flush_data: got %h", bus.m_data); end
      tick();
      // flush on an empty accumulator produces nothing
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_m_valid: got %b want 0", bus.m_valid); end
         tick();
      end
      // flush together with the completing sample
      for (int j = 1; j <= 8; j++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(256 + j);
         bus.flush   = (j == 8);
         tick();
      end
      bus.s_valid = 1'b0;
      bus.flush   = 1'b0;
      @(negedge clock);
      checks++; if (bus.m_valid !== 1'b1 || bus.m_partial !== 1'b0) begin errors++; $display("FAIL flush_full_word: got valid=%b partial=%b want 1/0", bus.m_valid, bus.m_partial); end
      tick();
      // flush while the output register is busy is held
      bus.m_ready = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(512 + j);
         tick();
      end
      bus.s_valid = 1'b0;
      bus.flush   = 1'b1;
      tick();
      bus.flush   = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h0BAD;
      @(negedge clock);
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL flush_pend_s_ready: got %b want 0", bus.s_ready); end
      tick();
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      tick();
      @(negedge clock);
      checks++; if (bus.m_valid !== 1'b1 || bus.m_partial !== 1'b1 || bus.m_data !== 128'h020A_0209) begin
         errors++;
         $display("FAIL flush_pend_word: got valid=%b partial=%b data=%h want 1/1/%h", bus.m_valid, bus.m_partial, bus.m_data, 128'h020A_0209);
      end
      tick();
   endtask
`endif

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.flush   = 1'b0;
      bus.m_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_random();
      test_drain();
      test_reset_mid();
      test_drain();
`ifdef PACK_FLUSH_EN
      test_flush();
      test_drain();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
